// File: rtl/tetris_pio_bank.sv
// Avalon-MM I/O bank for the Tetris SoC: hex/LED/keycode outputs, debounced
// push-buttons with press capture, write-1-to-clear edges and a masked level irq.
module tetris_pio_bank #(
   parameter int HEX_W    = 16,
   parameter int LED_W    = 14,
   parameter int KEY_W    = 2,
   parameter int DEBOUNCE = 50000
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic [2:0]        avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              irq,
   output logic [HEX_W-1:0]  hex_digits_export,
   output logic [LED_W-1:0]  leds_export,
   output logic [7:0]        keycode_export,
   input  logic [KEY_W-1:0]  key_external_connection_export
);
   localparam int CW = $clog2(DEBOUNCE) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   typedef enum logic {IDLE = 1'b0, COUNTING = 1'b1} db_state_t;

   logic [HEX_W-1:0] hex_reg;
   logic [LED_W-1:0] led_reg, led_next;
   logic [7:0]       keycode_reg;
   logic [KEY_W-1:0] mask_reg, edge_reg, edge_next;
   logic [KEY_W-1:0] stable, press, w1c;
   logic             irq_reg;
   logic [31:0]      rdata_reg, rdata_next;

   // Upper write-data bits are intentionally ignored for narrow registers.
   wire unused_wdata = ^avs_writedata;

   generate
      for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
         logic [1:0]    sync_reg;
         logic          stable_reg;
         logic [CW-1:0] cnt_reg;
         db_state_t     state_reg, state_next;
         logic          mismatch, accept, cnt_inc;

         assign mismatch = sync_reg[1] != stable_reg;

         always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
               sync_reg  <= 2'b11;
               state_reg <= IDLE;
            end else begin
               sync_reg  <= {sync_reg[0], key_external_connection_export[gi]};
               state_reg <= state_next;
            end
         end

         always_comb begin
            state_next = state_reg;
            case (state_reg)
               IDLE:     if (mismatch) state_next = COUNTING;
               COUNTING: if (!mismatch || cnt_reg == CNT_LAST) state_next = IDLE;
               default:  state_next = IDLE;
            endcase
         end

         // The count is checked before incrementing, so acceptance lands
         // exactly DEBOUNCE cycles after sync changes.
         always_comb begin
            accept  = 1'b0;
            cnt_inc = 1'b0;
            if (mismatch) begin
               if (state_reg == COUNTING && cnt_reg == CNT_LAST)
                  accept = 1'b1;
               else
                  cnt_inc = 1'b1;
            end
         end

         always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
               cnt_reg    <= '0;
               stable_reg <= 1'b1;
            end else begin
               cnt_reg <= cnt_inc ? cnt_reg + CW'(1) : '0;
               if (accept)
                  stable_reg <= sync_reg[1];
            end
         end

         assign stable[gi] = stable_reg;
         assign press[gi]  = accept & stable_reg;
      end
   endgenerate

   assign w1c       = (avs_write && avs_address == 3'd4) ? avs_writedata[KEY_W-1:0] : '0;
   assign edge_next = (edge_reg & ~w1c) | press;

   always_comb begin
      led_next = led_reg;
      if (avs_write) begin
         case (avs_address)
            3'd1:    led_next = avs_writedata[LED_W-1:0];
            3'd6:    led_next = led_reg | avs_writedata[LED_W-1:0];
            3'd7:    led_next = led_reg & ~avs_writedata[LED_W-1:0];
            default: led_next = led_reg;
         endcase
      end
   end

   always_comb begin
      rdata_next = rdata_reg;
      if (avs_read) begin
         rdata_next = '0;
         case (avs_address)
            3'd0:    rdata_next[HEX_W-1:0] = hex_reg;
            3'd1:    rdata_next[LED_W-1:0] = led_reg;
            3'd2:    rdata_next[7:0]       = keycode_reg;
            3'd3:    rdata_next[KEY_W-1:0] = stable;
            3'd4:    rdata_next[KEY_W-1:0] = edge_reg;
            3'd5:    rdata_next[KEY_W-1:0] = mask_reg;
            default: rdata_next = '0;
         endcase
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         hex_reg     <= '0;
         led_reg     <= '0;
         keycode_reg <= '0;
         mask_reg    <= '0;
         edge_reg    <= '0;
         irq_reg     <= 1'b0;
         rdata_reg   <= '0;
      end else begin
         if (avs_write && avs_address == 3'd0) hex_reg     <= avs_writedata[HEX_W-1:0];
         if (avs_write && avs_address == 3'd2) keycode_reg <= avs_writedata[7:0];
         if (avs_write && avs_address == 3'd5) mask_reg    <= avs_writedata[KEY_W-1:0];
         led_reg   <= led_next;
         edge_reg  <= edge_next;
         irq_reg   <= |(edge_reg & mask_reg);
         rdata_reg <= rdata_next;
      end
   end

   assign avs_readdata      = rdata_reg;
   assign irq               = irq_reg;
   assign hex_digits_export = hex_reg;
   assign leds_export       = led_reg;
   assign keycode_export    = keycode_reg;
endmodule

// File: tb/tb_tetris_pio_bank.sv
// Directed bench for tetris_pio_bank with DEBOUNCE=4; read results are
// checked through an expected-value queue.
module tb_tetris_pio_bank;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  addr;
   logic        rd, wr;
   logic [31:0] wdata;
   logic [1:0]  keys;
   wire  [31:0] rdata;
   wire         irq;
   wire  [15:0] hex;
   wire  [13:0] leds;
   wire  [7:0]  kc;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   tetris_pio_bank #(.HEX_W(16), .LED_W(14), .KEY_W(2), .DEBOUNCE(4)) dut (
      .clk_clk(clk),
      .reset_reset(rst),
      .avs_address(addr),
      .avs_read(rd),
      .avs_write(wr),
      .avs_writedata(wdata),
      .avs_readdata(rdata),
      .irq(irq),
      .hex_digits_export(hex),
      .leds_export(leds),
      .keycode_export(kc),
      .key_external_connection_export(keys)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
         $display("ok   %s observed=0x%0h", tag, obs);
      end else
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      addr = a; wdata = d; wr = 1'b1;
      tick();
      wr = 1'b0;
   endtask

   // Issue a read, queue its expectation, compare when readdata is valid.
   task automatic issue_rd(input logic [2:0] a, input logic [31:0] e, input string t);
      addr = a; rd = 1'b1;
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic retire_rd();
      logic [31:0] e;
      string t;
      rd = 1'b0;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, rdata, e);
   endtask

   task automatic bus_rd(input logic [2:0] a, input logic [31:0] e, input string t);
      issue_rd(a, e, t);
      tick();
      retire_rd();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; keys = 2'b11;
      tick(2);
      check("rst_rdata", rdata, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      check("rst_exports", {kc, leds, hex[9:0]}, 32'h0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++)
         bus_rd(3'(i), (i == 3) ? 32'h3 : 32'h0, $sformatf("rst_read_a%0d", i));

      bus_wr(3'd0, 32'hFFFF_1234);
      check("hex_export", {16'h0, hex}, 32'h1234);
      bus_wr(3'd1, 32'h0000_3FFF);
      check("led_export", {18'h0, leds}, 32'h3FFF);
      bus_wr(3'd2, 32'h0000_01A5);
      check("keycode_export", {24'h0, kc}, 32'hA5);
      bus_wr(3'd7, 32'h0000_000F);
      check("led_clr", {18'h0, leds}, 32'h3FF0);
      bus_wr(3'd6, 32'h0000_0001);
      check("led_set", {18'h0, leds}, 32'h3FF1);
      bus_rd(3'd1, 32'h3FF1, "led_read");
      bus_rd(3'd2, 32'hA5, "keycode_read");
      bus_rd(3'd0, 32'h1234, "hex_read");

      // Read and write of HEX in the same cycle returns the old value.
      wdata = 32'h5678; wr = 1'b1;
      issue_rd(3'd0, 32'h1234, "rw_same_cycle");
      tick();
      wr = 1'b0;
      retire_rd();
      check("rw_hex_export", {16'h0, hex}, 32'h5678);
      tick(3);
      check("rdata_hold", rdata, 32'h1234);

      bus_wr(3'd5, 32'h1);

      // Key0 press: stable flips exactly 6 edges after the pin changes.
      keys[0] = 1'b0;
      tick(5);
      issue_rd(3'd3, 32'h3, "key_state_edge6_old");
      tick();
      retire_rd();
      check("irq_not_yet", {31'b0, irq}, 32'h0);
      issue_rd(3'd3, 32'h2, "key_state_pressed");
      tick();
      retire_rd();
      check("irq_after_press", {31'b0, irq}, 32'h1);
      bus_rd(3'd4, 32'h1, "edge_set");
      keys[0] = 1'b1;
      tick(10);
      bus_rd(3'd4, 32'h1, "release_not_captured");
      bus_rd(3'd3, 32'h3, "key_state_released");

      bus_wr(3'd4, 32'h1);
      check("irq_lag", {31'b0, irq}, 32'h1);
      tick();
      check("irq_cleared", {31'b0, irq}, 32'h0);
      bus_rd(3'd4, 32'h0, "edge_cleared");

      // Short bounce on key1 is rejected.
      keys[1] = 1'b0;
      tick(3);
      keys[1] = 1'b1;
      tick(10);
      bus_rd(3'd3, 32'h3, "bounce_state");
      bus_rd(3'd4, 32'h0, "bounce_edge");

      // Pending EDGE[0] plus W1C in the same cycle as a new accepted press.
      keys[0] = 1'b0; tick(10);
      keys[0] = 1'b1; tick(10);
      bus_rd(3'd4, 32'h1, "edge_pending");
      keys[0] = 1'b0;
      tick(5);
      bus_wr(3'd4, 32'h1);
      check("prio_irq_a", {31'b0, irq}, 32'h1);
      tick();
      check("prio_irq_b", {31'b0, irq}, 32'h1);
      bus_rd(3'd4, 32'h1, "edge_priority");
      keys[0] = 1'b1;
      tick(10);
      bus_wr(3'd4, 32'h1);
      check("prio_clr_lag", {31'b0, irq}, 32'h1);
      tick();
      check("prio_clr_irq", {31'b0, irq}, 32'h0);
      bus_rd(3'd4, 32'h0, "prio_clr_edge");

      // Reset in the middle of a key0 count with EDGE[1] pending.
      keys[1] = 1'b0; tick(10);
      keys[1] = 1'b1; tick(10);
      bus_rd(3'd4, 32'h2, "edge1_pending");
      keys[0] = 1'b0;
      tick(4);
      rst = 1'b1;
      tick(2);
      check("midrst_rdata", rdata, 32'h0);
      check("midrst_irq", {31'b0, irq}, 32'h0);
      check("midrst_hex", {16'h0, hex}, 32'h0);
      rst = 1'b0;
      bus_rd(3'd4, 32'h0, "midrst_edge");
      bus_rd(3'd5, 32'h0, "midrst_mask");
      bus_rd(3'd1, 32'h0, "midrst_led");
      tick(2);
      issue_rd(3'd3, 32'h3, "midrst_full_hold_old");
      tick();
      retire_rd();
      issue_rd(3'd3, 32'h2, "midrst_full_hold_new");
      tick();
      retire_rd();
      bus_rd(3'd4, 32'h1, "midrst_edge_again");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/tetris_pio_bank.md
# tetris_pio_bank

Parametrised Avalon-MM I/O peripheral for the Tetris SoC. It replaces the separate hex-digit, LED, keycode and push-button PIOs with a single slave. Output widths are configurable, and it adds per-key debouncing, press-edge capture with write-1-to-clear, an interrupt mask and atomic LED set/clear. The Nios II reaches it through the system interconnect; its conduits drive the board HEX decoders, the LEDs and the keycode bus to the game logic.

## Interface
- HEX_W, 16, width of hex-digit output register (1..32)
- LED_W, 14, width of LED output register (1..32)
- KEY_W, 2, number of push-button inputs (1..32)
- DEBOUNCE, 50000, cycles a synchronised key level must hold before it is accepted (>=2)
- clk_clk  input  1  system clock; all logic on rising edge
- reset_reset  input  1  asynchronous, active-high reset
- avs_address  input  3  word address
- avs_read  input  1  read strobe
- avs_write  input  1  write strobe
- avs_writedata  input  32  write data
- avs_readdata  output  32  read data, fixed read latency 1
- irq  output  1  level interrupt, registered
- hex_digits_export  output  HEX_W  hex digit register
- leds_export  output  LED_W  LED register
- keycode_export  output  8  keycode register
- key_external_connection_export  input  KEY_W  raw buttons, active-low, asynchronous

## Operation
- Register map, word addresses:
  - 0 HEX: R/W.
  - 1 LED: R/W.
  - 2 KEYCODE: R/W, bits 7:0.
  - 3 KEY_STATE: RO, debounced active-low levels.
  - 4 EDGE: R, write-1-to-clear.
  - 5 IRQ_MASK: R/W, KEY_W bits.
  - 6 LED_SET: WO, LED |= wdata.
  - 7 LED_CLR: WO, LED &= ~wdata.
- Writes use only the low register-width bits; upper bits are ignored. Reads zero-extend to 32 bits; reads of 6 and 7 return 0.
- Each key is synchronised by a 2-flop synchroniser to produce `sync`, then debounced:
  - Per-key counter, width $clog2(DEBOUNCE)+1.
  - If `sync` == `stable`: counter clears to 0.
  - Otherwise the counter increments. When the counter == DEBOUNCE-1, `stable` takes `sync` and the counter clears.
- Per-key debounce FSM: IDLE (sync==stable) -> COUNTING (mismatch) -> IDLE on accept or on bounce-back.
- EDGE[i] sets on the cycle `stable[i]` goes 1->0 (press). Releases are not captured.
- EDGE priority: a set in the same cycle as a W1C write of that bit wins (bit stays 1). Other bits clear normally.
- irq is registered: irq <= |(EDGE & IRQ_MASK). Writing IRQ_MASK or clearing EDGE deasserts irq one cycle later.
- Simultaneous read and write in one cycle: the write is performed and the read returns the pre-write value.
- Reset values: HEX=0, LED=0, KEYCODE=0, sync/stable all 1 (released), counters 0, EDGE=0, IRQ_MASK=0, irq=0, avs_readdata=0.
- Reset asserted mid-debounce discards the count. Reset asserted with EDGE pending drops the event.

## Timing
- Write issued at cycle N: register and conduit output change at edge N+1.
- Read issued at cycle N: avs_readdata valid at cycle N+1; it holds its value until the next read.
- No waitrequest; every access completes in one cycle.
- Key latency:
  - A clean raw transition reaches `sync` after 2 cycles.
  - `stable` changes DEBOUNCE cycles after `sync` changes: 2+DEBOUNCE total from raw pin.
  - EDGE sets in the same cycle as `stable`; irq rises 1 cycle after that.
- A bounce shorter than DEBOUNCE cycles produces no `stable` change and no EDGE.

## Test plan
- Reset, then read all 8 addresses -> readdata 0 except KEY_STATE = all ones; irq=0; all exports 0.
- Write HEX=0x1234, LED=0x3FFF, KEYCODE=0x1A5 -> hex_digits_export=0x1234 and leds_export=0x3FFF next cycle; keycode_export=0xA5. Then LED_CLR 0x000F -> 0x3FF0. Then LED_SET 0x0001 -> 0x3FF1.
- DEBOUNCE=4, KEY_W=2: hold key0 low 10 cycles -> KEY_STATE=2'b10 exactly 6 cycles after the pin edge; EDGE=2'b01. With IRQ_MASK=1, irq=1 one cycle later.
- DEBOUNCE=4: pulse key1 low for 3 cycles then high -> KEY_STATE unchanged and EDGE=0.
- EDGE[0] pending: write 1 to EDGE in the same cycle a new key0 press is accepted -> EDGE[0] remains 1 and irq stays 1. A W1C write in a later cycle clears it, and irq drops one cycle after that.
- Assert reset_reset mid-count on key0 -> counter and EDGE cleared, KEY_STATE all ones. After release, a full 2+DEBOUNCE hold is required again.
